// File: rtl/rob_nway_cdb.sv
// Reorder buffer with in-order allocate, N-channel CDB writeback and single in-order retire.
// Handles the store-commit handshake with the LSB and a one-cycle mispredict flush.
module rob_nway_cdb #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int N_CDB  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    input  logic [DATA_W-1:0]       alloc_pc,
    input  logic [REG_W-1:0]        alloc_rd,
    input  logic                    alloc_is_br,
    input  logic                    alloc_pred_tk,
    input  logic                    alloc_is_st,
    output logic [IDX_W-1:0]        alloc_tag,
    input  logic [N_CDB-1:0]        cdb_valid,
    input  logic [N_CDB*IDX_W-1:0]  cdb_tag,
    input  logic [N_CDB*DATA_W-1:0] cdb_data,
    input  logic [N_CDB-1:0]        cdb_taken,
    input  logic [N_CDB*DATA_W-1:0] cdb_target,
    input  logic [IDX_W-1:0]        qa_tag,
    input  logic [IDX_W-1:0]        qb_tag,
    output logic                    qa_rdy,
    output logic                    qb_rdy,
    output logic [DATA_W-1:0]       qa_val,
    output logic [DATA_W-1:0]       qb_val,
    output logic                    cm_valid,
    output logic [REG_W-1:0]        cm_rd,
    output logic [IDX_W-1:0]        cm_tag,
    output logic [DATA_W-1:0]       cm_data,
    output logic                    st_go,
    output logic [IDX_W-1:0]        st_tag,
    input  logic                    st_done,
    output logic                    bp_valid,
    output logic                    bp_taken,
    output logic [DATA_W-1:0]       bp_pc,
    output logic                    flush,
    output logic [DATA_W-1:0]       flush_pc,
    output logic [IDX_W:0]          count
);

    typedef enum logic [1:0] {RUN, WAIT_ST, FLUSH} state_t;

    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

    state_t state_q, state_d;
    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]   count_q, count_d;

    logic [DATA_W-1:0] pc_q     [DEPTH];
    logic [DATA_W-1:0] pc_d     [DEPTH];
    logic [REG_W-1:0]  rd_q     [DEPTH];
    logic [REG_W-1:0]  rd_d     [DEPTH];
    logic [DATA_W-1:0] result_q [DEPTH];
    logic [DATA_W-1:0] result_d [DEPTH];
    logic [DATA_W-1:0] target_q [DEPTH];
    logic [DATA_W-1:0] target_d [DEPTH];
    logic [DEPTH-1:0]  ready_q, ready_d, is_br_q, is_br_d, pred_q, pred_d;
    logic [DEPTH-1:0]  is_st_q, is_st_d, taken_q, taken_d;

    logic              cm_valid_q, cm_valid_d, st_go_q, st_go_d;
    logic              bp_valid_q, bp_valid_d, bp_taken_q, bp_taken_d;
    logic              flush_q, flush_d;
    logic [REG_W-1:0]  cm_rd_q, cm_rd_d;
    logic [IDX_W-1:0]  cm_tag_q, cm_tag_d, st_tag_q, st_tag_d;
    logic [DATA_W-1:0] cm_data_q, cm_data_d, bp_pc_q, bp_pc_d, flush_pc_q, flush_pc_d;

    logic do_alloc, do_retire, head_ready;

    assign alloc_ready = (count_q != FULL_COUNT) && (state_q == RUN);
    assign alloc_tag   = tail_q;
    assign count       = count_q;
    assign head_ready  = ready_q[head_q] && (count_q != '0);

    assign cm_valid = cm_valid_q;
    assign cm_rd    = cm_rd_q;
    assign cm_tag   = cm_tag_q;
    assign cm_data  = cm_data_q;
    assign st_go    = st_go_q;
    assign st_tag   = st_tag_q;
    assign bp_valid = bp_valid_q;
    assign bp_taken = bp_taken_q;
    assign bp_pc    = bp_pc_q;
    assign flush    = flush_q;
    assign flush_pc = flush_pc_q;

    // Operand lookup forwards same-cycle CDB results; later channels override earlier ones.
    always_comb begin
        qa_rdy = ready_q[qa_tag];
        qa_val = result_q[qa_tag];
        qb_rdy = ready_q[qb_tag];
        qb_val = result_q[qb_tag];
        for (int k = 0; k < N_CDB; k++) begin
            if (cdb_valid[k] && (cdb_tag[k*IDX_W +: IDX_W] == qa_tag)) begin
                qa_rdy = 1'b1;
                qa_val = cdb_data[k*DATA_W +: DATA_W];
            end
            if (cdb_valid[k] && (cdb_tag[k*IDX_W +: IDX_W] == qb_tag)) begin
                qb_rdy = 1'b1;
                qb_val = cdb_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        pc_d       = pc_q;
        rd_d       = rd_q;
        result_d   = result_q;
        target_d   = target_q;
        ready_d    = ready_q;
        is_br_d    = is_br_q;
        pred_d     = pred_q;
        is_st_d    = is_st_q;
        taken_d    = taken_q;
        cm_valid_d = 1'b0;
        st_go_d    = 1'b0;
        bp_valid_d = 1'b0;
        flush_d    = 1'b0;
        cm_rd_d    = cm_rd_q;
        cm_tag_d   = cm_tag_q;
        cm_data_d  = cm_data_q;
        st_tag_d   = st_tag_q;
        bp_taken_d = bp_taken_q;
        bp_pc_d    = bp_pc_q;
        flush_pc_d = flush_pc_q;
        do_alloc   = 1'b0;
        do_retire  = 1'b0;

        if (rdy) begin
            if (state_q == FLUSH) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                ready_d = '0;
                state_d = RUN;
            end else begin
                do_alloc = alloc_valid && alloc_ready;
                if (do_alloc) begin
                    pc_d[tail_q]    = alloc_pc;
                    rd_d[tail_q]    = alloc_rd;
                    is_br_d[tail_q] = alloc_is_br;
                    pred_d[tail_q]  = alloc_pred_tk;
                    is_st_d[tail_q] = alloc_is_st;
                    ready_d[tail_q] = 1'b0;
                    tail_d          = tail_q + 1'b1;
                end
                for (int k = 0; k < N_CDB; k++) begin
                    if (cdb_valid[k]) begin
                        ready_d[cdb_tag[k*IDX_W +: IDX_W]]  = 1'b1;
                        result_d[cdb_tag[k*IDX_W +: IDX_W]] = cdb_data[k*DATA_W +: DATA_W];
                        taken_d[cdb_tag[k*IDX_W +: IDX_W]]  = cdb_taken[k];
                        target_d[cdb_tag[k*IDX_W +: IDX_W]] = cdb_target[k*DATA_W +: DATA_W];
                    end
                end

                // Stores hand off to the LSB first and only retire once it reports completion.
                if (state_q == RUN) begin
                    if (head_ready && is_st_q[head_q]) begin
                        st_go_d  = 1'b1;
                        st_tag_d = head_q;
                        state_d  = WAIT_ST;
                    end else if (head_ready) begin
                        do_retire  = 1'b1;
                        cm_valid_d = (rd_q[head_q] != '0);
                        cm_rd_d    = rd_q[head_q];
                        cm_tag_d   = head_q;
                        cm_data_d  = result_q[head_q];
                        if (is_br_q[head_q]) begin
                            bp_valid_d = 1'b1;
                            bp_taken_d = taken_q[head_q];
                            bp_pc_d    = pc_q[head_q];
                            if (taken_q[head_q] != pred_q[head_q]) begin
                                flush_d    = 1'b1;
                                flush_pc_d = taken_q[head_q] ? target_q[head_q]
                                                             : pc_q[head_q] + DATA_W'(4);
                                state_d    = FLUSH;
                            end
                        end
                    end
                end else if (st_done) begin
                    do_retire = 1'b1;
                    state_d   = RUN;
                end

                if (do_retire) begin
                    head_d = head_q + 1'b1;
                end
                if (do_alloc && !do_retire) begin
                    count_d = count_q + 1'b1;
                end else if (!do_alloc && do_retire) begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            pc_q       <= '{default: '0};
            rd_q       <= '{default: '0};
            result_q   <= '{default: '0};
            target_q   <= '{default: '0};
            ready_q    <= '0;
            is_br_q    <= '0;
            pred_q     <= '0;
            is_st_q    <= '0;
            taken_q    <= '0;
            cm_valid_q <= 1'b0;
            st_go_q    <= 1'b0;
            bp_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            cm_rd_q    <= '0;
            cm_tag_q   <= '0;
            cm_data_q  <= '0;
            st_tag_q   <= '0;
            bp_taken_q <= 1'b0;
            bp_pc_q    <= '0;
            flush_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pc_q       <= pc_d;
            rd_q       <= rd_d;
            result_q   <= result_d;
            target_q   <= target_d;
            ready_q    <= ready_d;
            is_br_q    <= is_br_d;
            pred_q     <= pred_d;
            is_st_q    <= is_st_d;
            taken_q    <= taken_d;
            cm_valid_q <= cm_valid_d;
            st_go_q    <= st_go_d;
            bp_valid_q <= bp_valid_d;
            flush_q    <= flush_d;
            cm_rd_q    <= cm_rd_d;
            cm_tag_q   <= cm_tag_d;
            cm_data_q  <= cm_data_d;
            st_tag_q   <= st_tag_d;
            bp_taken_q <= bp_taken_d;
            bp_pc_q    <= bp_pc_d;
            flush_pc_q <= flush_pc_d;
        end
    end

endmodule
